// File: rtl/axi_bus_arbiter_if.sv
// AXI4-Lite master-side bundle used by axi_bus_arbiter.
//   master modport : the arbiter drives the address/data valids, bready and rready
//                    and samples the slave-side readies, responses and read data.
//   slave  modport : the interconnect (or a bench slave model) takes the opposite directions.
// Data bus is fixed at 32 bits; only the address width is parameterised.
interface axi_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  // write-address channel
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  // write-data channel
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  // write-response channel
  logic                  bready;
  logic                  bvalid;
  logic [1:0]            bresp;
  // read-address channel
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  // read-data channel
  logic                  rready;
  logic                  rvalid;
  logic [31:0]           rdata;
  logic [1:0]            rresp;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_bus_arbiter.sv
// axi_bus_arbiter
// Shares one AXI4-Lite master port between two byte-wide requesters
// (port 0: CPU bus bridge, port 1: debug/DMA engine). Requests are granted
// round-robin, one transaction is outstanding at a time, and each byte access
// is mapped onto a 32-bit word through lane selection.
// Ports:
//   AXI_CLK              clock, all logic on the rising edge
//   RESETN               synchronous reset, active-low
//   req_valid/req_write  per-requester request and direction (1 = write)
//   req_addr0/1          byte address of each requester
//   req_wdata0/1         write byte of each requester
//   req_ready            one-cycle pulse: request n accepted and captured
//   req_done             one-cycle pulse: transaction n complete
//   req_rdata, req_err   byte of the last completed read / last response != OKAY
//   axi                  AXI4-Lite master port (axi_bus_arbiter_if.master)
module axi_bus_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  AXI_CLK,
  input  logic                  RESETN,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [7:0]            req_wdata0,
  input  logic [7:0]            req_wdata1,
  output logic [1:0]            req_ready,
  output logic [1:0]            req_done,
  output logic [7:0]            req_rdata,
  output logic                  req_err,
  axi_bus_arbiter_if.master     axi
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  state_t                state, state_next;
  logic                  last_grant;   // port granted most recently
  logic                  grant;        // port that wins if a grant happens this cycle
  logic                  grant_any;
  logic                  cur_port;     // owner of the transaction in flight
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [7:0]            cur_wdata;
  logic                  aw_done;      // AW beat already accepted
  logic                  w_done;       // W beat already accepted
  logic [7:0]            rdata_byte;

  // Round-robin: a lone requester always wins; on a tie the port that did
  // not win last time goes first, so an idle port never consumes a turn.
  always_comb begin
    grant_any = |req_valid;
    if (&req_valid) grant = ~last_grant;
    else            grant = req_valid[1];
  end

  // Byte-to-word mapping: word-aligned address, byte replicated on all lanes,
  // strobe picks the addressed lane.
  assign axi.awaddr  = {cur_addr[ADDR_WIDTH-1:2], 2'b00};
  assign axi.araddr  = {cur_addr[ADDR_WIDTH-1:2], 2'b00};
  assign axi.wdata   = {4{cur_wdata}};
  assign axi.wstrb   = 4'b0001 << cur_addr[1:0];
  assign rdata_byte  = axi.rdata[{cur_addr[1:0], 3'b000} +: 8];

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_next  = state;
    req_ready   = 2'b00;
    req_done    = 2'b00;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;

    unique case (state)
      IDLE: begin
        // Reset is synchronous, so the combinational accept must be masked
        // while RESETN is low or a request would appear accepted during reset.
        if (grant_any && RESETN) begin
          req_ready[grant] = 1'b1;
          state_next       = req_write[grant] ? WR_ADDR_DATA : RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        // AW and W are independent: each valid drops only after its own beat.
        axi.awvalid = ~aw_done;
        axi.wvalid  = ~w_done;
        if ((aw_done || axi.awready) && (w_done || axi.wready))
          state_next = WR_RESP;
      end
      WR_RESP: begin
        axi.bready = 1'b1;
        if (axi.bvalid) state_next = DONE;
      end
      RD_ADDR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_next = RD_DATA;
      end
      RD_DATA: begin
        axi.rready = 1'b1;
        if (axi.rvalid) state_next = DONE;
      end
      DONE: begin
        // Completion only; the next grant is decided back in IDLE.
        req_done[cur_port] = 1'b1;
        state_next         = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge AXI_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or process order.
    if (!RESETN) state <= IDLE;
    else         state <= state_next;
  end

  // Request capture, beat tracking and completion results.
  always_ff @(posedge AXI_CLK) begin
    if (!RESETN) begin
      last_grant <= 1'b1;         // port 0 wins the first tie
      cur_port   <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      req_rdata  <= '0;
      req_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            cur_port   <= grant;
            last_grant <= grant;
            cur_addr   <= grant ? req_addr1  : req_addr0;
            cur_wdata  <= grant ? req_wdata1 : req_wdata0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
          end
        end
        WR_ADDR_DATA: begin
          if (axi.awvalid && axi.awready) aw_done <= 1'b1;
          if (axi.wvalid  && axi.wready)  w_done  <= 1'b1;
        end
        WR_RESP: begin
          if (axi.bvalid) req_err <= (axi.bresp != 2'b00);
        end
        RD_DATA: begin
          if (axi.rvalid) begin
            req_rdata <= rdata_byte;
            req_err   <= (axi.rresp != 2'b00);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
